// File: rtl/cereal_rx.sv
`default_nettype none
// ============================================================================
// Module   : cereal_rx
// Purpose  : 8N1 UART receiver. It recovers frames from an asynchronous serial
//            line and holds each received byte in a one-entry register with a
//            valid/ack handshake. It reports framing errors and overruns.
// Revision : 1.0 - initial release
// ============================================================================
module cereal_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ack,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int                 c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_END  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_END = c_CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_rx_meta;
    logic               r_rx_s;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_ferr;
    logic               r_ovr;

    logic               w_half_hit;
    logic               w_bit_hit;

    assign w_half_hit = (r_cnt == c_HALF_END);
    assign w_bit_hit  = (r_cnt == c_BIT_END);

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
    assign busy      = (r_state != S_IDLE);

    // Two-flop synchronizer; presets to the idle (high) line level
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame state machine, bit timing, holding register and status flags
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;

            // Consumer handshake; a frame completing on this same edge may
            // override valid below so the new byte is kept.
            if (ack && r_valid) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (w_half_hit) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        // A high line at mid start bit means the edge was a glitch
                        r_state <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_bit_hit) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= r_rx_s;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (w_bit_hit) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            if (!r_valid || ack) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_ovr <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_WAIT_IDLE: begin
                    // Hold off until the line returns high so a break is not
                    // decoded as a stream of zero frames.
                    r_cnt <= '0;
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cereal_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cereal_rx
// Purpose  : Self-checking bench for cereal_rx with 16 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cereal_rx;

    localparam int C = 16;
    localparam int H = C / 2;

    logic       sysclk  = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx      = 1'b1;
    logic       ack     = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int checks     = 0;
    int errors     = 0;
    int ferr_total = 0;

    cereal_rx #(.CLKS_PER_BIT(C)) dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .ack       (ack),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 sysclk = ~sysclk;

    // Count every cycle frame_err is high
    always @(posedge sysclk) begin
        if (frame_err) ferr_total <= ferr_total + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack_first;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ovr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (C) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge sysclk);
        end
        rx = stop;
        repeat (C) @(negedge sysclk);
    endtask

    // Frame, optional break after a bad stop bit, then two idle bit times
    task automatic frame_settle(input logic [7:0] b, input logic stop);
        send_frame(b, stop);
        if (!stop) repeat (3 * C) @(negedge sysclk);
        rx = 1'b1;
        repeat (2 * C) @(negedge sysclk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge sysclk);
        ack = 1'b0;
        @(negedge sysclk);
    endtask

    initial begin
        int         base;
        int         cyc;
        logic [7:0] got[3];
        logic [7:0] exp3[3];
        logic [7:0] b;
        logic       stop;
        logic       a;
        logic [7:0] m_data;
        logic       m_valid;
        logic       m_ovr;
        int         m_ferr;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1};
        vecs[2] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 0};
        vecs[3] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 0};
        vecs[4] = '{8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 0};
        vecs[5] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 0};
        exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h81;

        // Reset values
        repeat (3) @(negedge sysclk);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge sysclk);

        // Good byte with latency measurement from the start edge
        cyc = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!valid && cyc < 400) begin
                    @(posedge sysclk);
                    #1;
                    cyc++;
                end
            end
        join
        checks++;
        if (cyc < 153 || cyc > 157) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected 155 +-2", cyc);
        end
        rx = 1'b1;
        repeat (2 * C) @(negedge sysclk);
        chk("lat_data", 32'(data_out), 32'hA5);
        chk("lat_busy", 32'(busy), 32'h0);
        chk("lat_flags", 32'({frame_err, overrun}), 32'h0);
        pulse_ack();
        chk("ack_valid", 32'(valid), 32'h0);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].ack_first) pulse_ack();
            base = ferr_total;
            frame_settle(vecs[i].data, vecs[i].stop);
            chk($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].exp_ovr));
            chk($sformatf("vec%0d_ferr", i), 32'(ferr_total - base), 32'(vecs[i].exp_ferr));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
        end

        // Overrun, handshake and simultaneous ack at the stop sample
        pulse_ack();
        frame_settle(8'h11, 1'b1);
        frame_settle(8'h22, 1'b1);
        chk("ovr_data", 32'(data_out), 32'h11);
        chk("ovr_flag", 32'(overrun), 32'h1);
        pulse_ack();
        chk("ovr_ack_valid", 32'(valid), 32'h0);
        chk("ovr_ack_flag", 32'(overrun), 32'h0);
        frame_settle(8'h11, 1'b1);
        chk("pend_valid", 32'(valid), 32'h1);
        fork
            send_frame(8'h33, 1'b1);
            begin
                repeat (2 + H + 9 * C) @(negedge sysclk);
                ack = 1'b1;
                @(negedge sysclk);
                ack = 1'b0;
            end
        join
        rx = 1'b1;
        repeat (2 * C) @(negedge sysclk);
        chk("sim_data", 32'(data_out), 32'h33);
        chk("sim_valid", 32'(valid), 32'h1);
        chk("sim_ovr", 32'(overrun), 32'h0);

        // Glitch shorter than half a bit
        pulse_ack();
        base = ferr_total;
        rx = 1'b0;
        repeat (4) @(negedge sysclk);
        chk("glitch_busy_hi", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (8) @(negedge sysclk);
        chk("glitch_busy_lo", 32'(busy), 32'h0);
        chk("glitch_valid", 32'(valid), 32'h0);
        chk("glitch_ferr", 32'(ferr_total - base), 32'h0);
        repeat (C) @(negedge sysclk);

        // Back-to-back frames with no idle gap, each one acked
        base = ferr_total;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                send_frame(8'h81, 1'b1);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    cyc = 0;
                    while (!valid && cyc < 300) begin
                        @(negedge sysclk);
                        cyc++;
                    end
                    got[k] = data_out;
                    chk($sformatf("b2b%0d_timeout", k), 32'(cyc < 300), 32'h1);
                    ack = 1'b1;
                    @(negedge sysclk);
                    ack = 1'b0;
                end
            end
        join
        rx = 1'b1;
        repeat (2 * C) @(negedge sysclk);
        for (int k = 0; k < 3; k++) chk($sformatf("b2b%0d_data", k), 32'(got[k]), 32'(exp3[k]));
        chk("b2b_ovr", 32'(overrun), 32'h0);
        chk("b2b_ferr", 32'(ferr_total - base), 32'h0);

        // Randomized frames against a transaction-level model of the holding register
        m_data  = 8'h81;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            a    = 1'($urandom_range(0, 1));
            if (a && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            m_ferr = 0;
            if (!stop)         m_ferr = 1;
            else if (m_valid)  m_ovr  = 1'b1;
            else begin
                m_data  = b;
                m_valid = 1'b1;
            end
            if (a) pulse_ack();
            base = ferr_total;
            frame_settle(b, stop);
            chk($sformatf("rnd%0d_data", n), 32'(data_out), 32'(m_data));
            chk($sformatf("rnd%0d_valid", n), 32'(valid), 32'(m_valid));
            chk($sformatf("rnd%0d_ovr", n), 32'(overrun), 32'(m_ovr));
            chk($sformatf("rnd%0d_ferr", n), 32'(ferr_total - base), 32'(m_ferr));
        end

        // Reset during data bit 4, then a clean frame
        pulse_ack();
        frame_settle(8'h5A, 1'b1);
        chk("pre_rst_valid", 32'(valid), 32'h1);
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (3 + H + 4 * C + 2) @(negedge sysclk);
                reset_n = 1'b0;
                #1;
                chk("mid_rst_data", 32'(data_out), 32'h00);
                chk("mid_rst_valid", 32'(valid), 32'h0);
                chk("mid_rst_busy", 32'(busy), 32'h0);
                chk("mid_rst_flags", 32'({frame_err, overrun}), 32'h0);
                repeat (4) @(negedge sysclk);
                reset_n = 1'b1;
            end
        join
        rx = 1'b1;
        repeat (2 * C) @(negedge sysclk);
        chk("post_rst_valid", 32'(valid), 32'h0);
        base = ferr_total;
        frame_settle(8'hC3, 1'b1);
        chk("post_rst_data", 32'(data_out), 32'hC3);
        chk("post_rst_valid2", 32'(valid), 32'h1);
        chk("post_rst_ferr", 32'(ferr_total - base), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
